// File: rtl/tdc_interval_counter.sv
// Coarse TDC interval counter: measures clk cycles between synchronized start/stop edges,
// averages 2^AVG_LOG2 intervals and presents the result over a valid/ready handshake.
module tdc_interval_counter #(
  parameter int CNT_W       = 24,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int AVG_LOG2    = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tdc_start,
  input  logic             tdc_stop,
  input  logic             clear,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_data,
  output logic             res_timeout,
  output logic [7:0]       drop_cnt
);

  localparam int SUM_W = CNT_W + AVG_LOG2;
  localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    ACCUM  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  state_t           state_q;
  logic             start_s1_q, start_s2_q, stop_s1_q, stop_s2_q;
  logic [CNT_W-1:0] cnt_q, n_q, res_data_q;
  logic [SUM_W-1:0] sum_q;
  logic [IDX_W-1:0] idx_q;
  logic             busy_q, res_valid_q, res_timeout_q;
  logic [7:0]       drop_q;

  logic             start_edge_s, stop_edge_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [SUM_W-1:0] sum_new_s;

  assign start_edge_s = start_s1_q & ~start_s2_q;
  assign stop_edge_s  = stop_s1_q & ~stop_s2_q;
  assign cnt_inc_s    = cnt_q + CNT_W'(1);
  assign sum_new_s    = sum_q + SUM_W'(n_q);

  // Input synchronizers; deliberately untouched by the soft clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_s1_q <= 1'b0;
      start_s2_q <= 1'b0;
      stop_s1_q  <= 1'b0;
      stop_s2_q  <= 1'b0;
    end else begin
      start_s1_q <= tdc_start;
      start_s2_q <= start_s1_q;
      stop_s1_q  <= tdc_stop;
      stop_s2_q  <= stop_s1_q;
    end
  end

  // Measurement FSM with its datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      n_q           <= '0;
      sum_q         <= '0;
      idx_q         <= '0;
      busy_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
      drop_q        <= 8'd0;
    end else if (clear) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      n_q           <= '0;
      sum_q         <= '0;
      idx_q         <= '0;
      busy_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
      drop_q        <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          // Start wins over a coincident stop; a lone stop is ignored.
          if (start_edge_s) begin
            state_q <= COUNT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        COUNT: begin
          cnt_q <= cnt_inc_s;
          if (stop_edge_s) begin
            n_q     <= cnt_inc_s;
            state_q <= ACCUM;
          end else if (cnt_inc_s == TIMEOUT_LIM) begin
            state_q       <= OUTPUT;
            res_valid_q   <= 1'b1;
            res_timeout_q <= 1'b1;
            res_data_q    <= '1;
            sum_q         <= '0;
            idx_q         <= '0;
          end
        end
        ACCUM: begin
          if (idx_q == IDX_LAST) begin
            state_q       <= OUTPUT;
            res_valid_q   <= 1'b1;
            res_timeout_q <= 1'b0;
            res_data_q    <= CNT_W'(sum_new_s >> AVG_LOG2);
            sum_q         <= '0;
            idx_q         <= '0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            sum_q   <= sum_new_s;
            idx_q   <= idx_q + IDX_W'(1);
          end
        end
        OUTPUT: begin
          if (start_edge_s && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
          end
          if (res_ready) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_timeout = res_timeout_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_tdc_interval_counter.sv
// Scoreboard bench: two instances (no averaging, average of 4) share start/stop stimulus;
// expected results come from interval arithmetic pushed into per-instance queues.
module tb_tdc_interval_counter;

  localparam int CW = 24;
  localparam int TO = 50;

  typedef struct packed {
    logic          to;
    logic [CW-1:0] data;
  } res_t;

  logic          clk = 1'b0;
  logic          reset_n, tdc_start, tdc_stop, clear, ready0, ready2;
  logic          busy0, valid0, to0, busy2, valid2, to2;
  logic [CW-1:0] data0, data2;
  logic [7:0]    drop0, drop2;

  res_t q0[$];
  res_t q2[$];
  int   total = 0;
  int   bad = 0;
  int   acc2 = 0;
  int   n2 = 0;

  tdc_interval_counter #(.CNT_W(CW), .TIMEOUT_CYC(TO), .AVG_LOG2(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .tdc_start(tdc_start), .tdc_stop(tdc_stop), .clear(clear),
    .busy(busy0), .res_valid(valid0), .res_ready(ready0), .res_data(data0),
    .res_timeout(to0), .drop_cnt(drop0));

  tdc_interval_counter #(.CNT_W(CW), .TIMEOUT_CYC(TO), .AVG_LOG2(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .tdc_start(tdc_start), .tdc_stop(tdc_stop), .clear(clear),
    .busy(busy2), .res_valid(valid2), .res_ready(ready2), .res_data(data2),
    .res_timeout(to2), .drop_cnt(drop2));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: each completed interval k yields k for the single instance and
  // contributes to a group of four (truncating mean) for the averaging instance.
  task automatic model_interval(input int k, input bit go0);
    if (go0) q0.push_back('{to: 1'b0, data: CW'(k)});
    acc2 += k;
    n2++;
    if (n2 == 4) begin
      q2.push_back('{to: 1'b0, data: CW'(acc2 / 4)});
      acc2 = 0;
      n2 = 0;
    end
  endtask

  // Start rises at cycle 0 (held hs cycles), stop rises at cycle k (held hp cycles).
  task automatic pair(input int k, input int hs, input int hp, input bit stop0,
                      input int restart, input bit go0);
    int len;
    model_interval(k, go0);
    len = (hs > k + hp) ? hs : k + hp;
    for (int c = 0; c < len; c++) begin
      tdc_start = (c < hs) || (c == restart);
      tdc_stop  = (stop0 && c == 0) || (c >= k && c < k + hp);
      tick();
    end
    tdc_start = 1'b0;
    tdc_stop  = 1'b0;
    repeat (6) tick();
    check("busy2_between", busy2, 0);
    if (ready0) check("busy0_between", busy0, 0);
  endtask

  task automatic do_timeout();
    int n = 0;
    bit seen = 1'b0;
    q0.push_back('{to: 1'b1, data: {CW{1'b1}}});
    q2.push_back('{to: 1'b1, data: {CW{1'b1}}});
    acc2 = 0;
    n2 = 0;
    tdc_start = 1'b1;
    while (!seen && n < 200) begin
      tick();
      tdc_start = 1'b0;
      n++;
      if (valid0) seen = 1'b1;
    end
    check("timeout_latency", n, 52);
    check("timeout_valid2", valid2, 1);
    repeat (6) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy0"}, busy0, 0);
    check({tag, "_valid0"}, valid0, 0);
    check({tag, "_data0"}, data0, 0);
    check({tag, "_to0"}, to0, 0);
    check({tag, "_drop0"}, drop0, 0);
    check({tag, "_busy2"}, busy2, 0);
    check({tag, "_valid2"}, valid2, 0);
    check({tag, "_data2"}, data2, 0);
  endtask

  // Monitor: pop and compare on each handshake, and require stable data while stalled.
  initial begin
    bit   hold0 = 1'b0;
    bit   hold2 = 1'b0;
    res_t held0, held2, exp;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hold0 = 1'b0;
        hold2 = 1'b0;
      end else begin
        if (hold0 && valid0) check("hold0", {to0, data0}, held0);
        if (hold2 && valid2) check("hold2", {to2, data2}, held2);
        if (valid0 && ready0) begin
          if (q0.size() == 0) begin
            total++;
            bad++;
            $display("FAIL res0_unexpected: got %0h expected none", {to0, data0});
          end else begin
            exp = q0.pop_front();
            check("res0", {to0, data0}, exp);
          end
        end
        if (valid2 && ready2) begin
          if (q2.size() == 0) begin
            total++;
            bad++;
            $display("FAIL res2_unexpected: got %0h expected none", {to2, data2});
          end else begin
            exp = q2.pop_front();
            check("res2", {to2, data2}, exp);
          end
        end
        hold0 = valid0 && !ready0;
        held0 = {to0, data0};
        hold2 = valid2 && !ready2;
        held2 = {to2, data2};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    tdc_start = 1'b0;
    tdc_stop = 1'b0;
    clear = 1'b0;
    ready0 = 1'b1;
    ready2 = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (2) tick();

    // Averaging group 10..13 -> 11
    for (int i = 0; i < 4; i++) pair(10 + i, 1, 1, 1'b0, -1, 1'b1);
    // Multi-cycle levels
    pair(20, 3, 2, 1'b0, -1, 1'b1);
    // Lone stop in IDLE is ignored
    tdc_stop = 1'b1;
    repeat (2) tick();
    tdc_stop = 1'b0;
    repeat (6) tick();
    check("stop_idle_busy0", busy0, 0);
    check("stop_idle_busy2", busy2, 0);
    // Coincident start/stop, then a second start during COUNT
    pair(15, 1, 1, 1'b1, -1, 1'b1);
    pair(14, 1, 1, 1'b0, 5, 1'b1);
    // Timeout discards the partial group; next group averages from zero
    do_timeout();
    for (int i = 0; i < 4; i++) pair(10 + i, 1, 1, 1'b0, -1, 1'b1);

    // Randomized intervals and level lengths
    for (int i = 0; i < 16; i++)
      pair($urandom_range(45, 1), $urandom_range(3, 1), $urandom_range(3, 1), 1'b0, -1, 1'b1);

    // Backpressure: hold one result while three starts arrive
    ready0 = 1'b0;
    pair(8, 1, 1, 1'b0, -1, 1'b1);
    for (int i = 0; i < 3; i++) pair($urandom_range(12, 5), 1, 1, 1'b0, -1, 1'b0);
    check("stall_valid0", valid0, 1);
    ready0 = 1'b1;
    repeat (3) tick();
    check("drop0_after", drop0, 3);
    check("busy0_after", busy0, 0);
    check("valid0_after", valid0, 0);

    // Asynchronous reset mid-COUNT
    tdc_start = 1'b1;
    tick();
    tdc_start = 1'b0;
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_count");
    tick();
    reset_n = 1'b1;
    acc2 = 0;
    n2 = 0;
    repeat (3) tick();
    pair(7, 1, 1, 1'b0, -1, 1'b1);

    // Soft clear while a result is pending
    ready0 = 1'b0;
    pair(9, 1, 1, 1'b0, -1, 1'b1);
    check("pend_valid0", valid0, 1);
    tdc_start = 1'b1;
    tick();
    tdc_start = 1'b0;
    repeat (3) tick();
    check("pend_drop0", drop0, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_reset_outputs("clear");
    q0.delete();
    acc2 = 0;
    n2 = 0;
    ready0 = 1'b1;
    repeat (3) tick();
    check("clear_valid0", valid0, 0);
    pair(12, 1, 1, 1'b0, -1, 1'b1);

    repeat (10) tick();
    check("q0_empty", q0.size(), 0);
    check("q2_empty", q2.size(), 0);
    check("drop2_final", drop2, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdc_interval_counter.md
# tdc_interval_counter

Coarse-time measurement stage that consumes the TDC start/stop pulses produced by the first-edge alignment stage. It counts `clk` cycles between each start and the following stop, and averages 2^AVG_LOG2 consecutive intervals. The averaged result is presented to the readout logic over a valid/ready handshake. It also handles timeouts and counts start events lost while the output is blocked.

## Interface
Parameters:
- `CNT_W`, 24, width of the coarse interval counter.
- `TIMEOUT_CYC`, 1000000, interval length that aborts a measurement; must be < 2^CNT_W.
- `AVG_LOG2`, 2, log2 of the number of intervals averaged per result (0..4).

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `tdc_start`  in  1  start indication from upstream stage; may stay high for several cycles.
- `tdc_stop`  in  1  stop indication from upstream stage; may stay high for several cycles.
- `clear`  in  1  synchronous soft reset; same effect as reset_n, excluding input sync flops.
- `busy`  out  1  high in any state other than IDLE.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  CNT_W  averaged interval in clk cycles.
- `res_timeout`  out  1  qualifies res_data: the measurement aborted on timeout.
- `drop_cnt`  out  8  saturating count of start edges ignored in OUTPUT state.

## Operation
- **Input conditioning**
  - Each input passes through two flops, s1 and s2.
  - Edge pulse = s1 & ~s2.
  - A level held high for several cycles yields exactly one edge.
- **State machine**
  - States: IDLE, COUNT, ACCUM, OUTPUT.
  - IDLE:
    - start_edge → COUNT, with cnt=0.
    - A stop_edge in IDLE is ignored.
    - If start and stop edges occur in the same cycle, start wins and stop is ignored.
  - COUNT:
    - cnt increments by 1 each cycle.
    - Further start edges are ignored.
    - stop_edge → ACCUM. The latched interval N equals the number of cycles from the start edge to the stop edge (stop edge k cycles after start edge gives N=k, minimum 1).
    - cnt reaching TIMEOUT_CYC with no stop edge → OUTPUT with:
      - res_timeout=1
      - res_data = all ones
      - sum and idx cleared (partial average discarded)
  - ACCUM:
    - sum += N, where sum is CNT_W+AVG_LOG2 bits wide and cannot overflow.
    - If idx == 2^AVG_LOG2−1: → OUTPUT with res_data = sum_new >> AVG_LOG2 (truncating), res_timeout=0, then sum and idx cleared.
    - Otherwise: idx++ and → IDLE.
  - OUTPUT:
    - res_valid=1; res_data and res_timeout are held stable.
    - The transfer happens when res_valid & res_ready; then → IDLE.
    - A start_edge here increments drop_cnt, saturating at 255.
- **drop_cnt** clears only on reset or clear.
- **clear / reset**
  - Take effect from any state, including mid-COUNT or mid-OUTPUT.
  - Go to IDLE; cnt, sum, idx, drop_cnt cleared.
  - res_valid drops; any pending result is lost.

## Timing
- Reset values:
  - busy=0, res_valid=0, res_data=0, res_timeout=0, drop_cnt=0
  - state IDLE, s1=s2=0
- Input latency: an input high first at edge t gives an edge pulse during cycle t+1 to t+2. Start and stop share this latency, so N is unaffected.
- Stop edge in COUNT at cycle S:
  - ACCUM in S+1.
  - res_valid asserted from S+2 when this is the last sample of the group.
- Back-to-back: a new start edge is accepted in the first IDLE cycle after ACCUM or after the handshake cycle.
- res_valid stays high until the handshake and is never withdrawn except by reset or clear.
- Timeout: res_valid is asserted the cycle after cnt reaches TIMEOUT_CYC.
- All outputs are registered.

## Test plan
- **Averaging**: AVG_LOG2=2, four start/stop pairs with intervals 10, 11, 12, 13 cycles → one result with res_data=11 and res_timeout=0; busy low between pairs.
- **Multi-cycle levels**: tdc_start high 3 cycles, tdc_stop high 2 cycles arriving 20 cycles later, AVG_LOG2=0 → res_data=20, single result.
- **Timeout**: TIMEOUT_CYC=50, start with no stop → res_valid 51 cycles after the start edge, res_timeout=1, res_data=0xFFFFFF. The next group then averages from zero.
- **Backpressure and drops**: res_ready low for 30 cycles with 3 start pulses applied meanwhile → res_data stable throughout, drop_cnt=3 after the handshake, FSM back in IDLE.
- **Edge conflicts**: stop in IDLE ignored; simultaneous start and stop in IDLE → counting starts; a second start during COUNT does not restart cnt.
- **Reset and clear**: reset_n asserted mid-COUNT and clear asserted in OUTPUT → all outputs at reset values next cycle; the following measurement of 7 cycles with AVG_LOG2=0 gives res_data=7.
